// File: rtl/fft_iter_addr_gen_if.sv
// fft_iter_addr_gen_if: sequencer inputs and RAM/ROM address outputs of the FFT address generator
// master drives EN/START/Wr/FIRST and observes the rest; slave is the generator side.
interface fft_iter_addr_gen_if #(
  parameter int LayWL  = 3,
  parameter int ButtWL = 4
);
  logic              EN;
  logic              START;
  logic              Wr;
  logic              FIRST;
  logic [ButtWL:0]   RD_ADDR_A;
  logic [ButtWL:0]   RD_ADDR_B;
  logic [ButtWL:0]   WR_ADDR_A;
  logic [ButtWL:0]   WR_ADDR_B;
  logic [ButtWL-1:0] W_ADDR;
  logic              RD_EN;
  logic              WR_EN;
  logic              SRC_SEL;
  logic [LayWL-1:0]  LAY_IDX;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  modport master (
    output EN, START, Wr, FIRST,
    input  RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, W_ADDR,
    input  RD_EN, WR_EN, SRC_SEL, LAY_IDX, BUSY, DONE, ERR
  );
  modport slave (
    input  EN, START, Wr, FIRST,
    output RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B, W_ADDR,
    output RD_EN, WR_EN, SRC_SEL, LAY_IDX, BUSY, DONE, ERR
  );
endinterface

// File: rtl/fft_iter_addr_gen.sv
// fft_iter_addr_gen: in-place radix-2 DIT FFT read/write/twiddle address and strobe generator
// Ports: CLK, RST_N (sync active-low), bus (slave): sequencer EN/START/Wr/FIRST in;
// RD/WR addresses, W_ADDR, RD_EN/WR_EN, SRC_SEL, LAY_IDX, BUSY, DONE, ERR out.
module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4
) (
  input logic                 CLK,
  input logic                 RST_N,
  fft_iter_addr_gen_if.slave  bus
);
  localparam int AW = ButtWL + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [ButtWL-1:0] b_q, b_d;
  logic [LayWL-1:0]  l_q, l_d;
  logic [AW-1:0]     wr_a_q, wr_a_d, wr_b_q, wr_b_d;
  logic              done_q, done_d, err_q, err_d;
  logic              run, last_b, last_l;
  logic [AW-1:0]     pos, grp, rd_a, rd_b, w_full;
  logic [LayWL-1:0]  w_sh;
  assign run    = state_q == RUN;
  assign last_b = b_q == ButtWL'(BUTTERFLYES - 1);
  assign last_l = l_q == LayWL'(LAYERS - 1);
  // butterfly b of layer l pairs addresses 2^l apart inside group b>>l
  assign pos    = AW'(b_q) & ((AW'(1) << l_q) - AW'(1));
  assign grp    = AW'(b_q) >> l_q;
  assign rd_a   = (grp << (l_q + LayWL'(1))) | pos;
  assign rd_b   = rd_a + (AW'(1) << l_q);
  assign w_sh   = LayWL'(LAYERS - 1) - l_q;
  assign w_full = pos << w_sh;
  assign bus.RD_ADDR_A = run ? rd_a : '0;
  assign bus.RD_ADDR_B = run ? rd_b : '0;
  assign bus.W_ADDR    = run ? w_full[ButtWL-1:0] : '0;
  assign bus.WR_ADDR_A = wr_a_q;
  assign bus.WR_ADDR_B = wr_b_q;
  assign bus.RD_EN     = run & bus.EN & ~bus.Wr;
  assign bus.WR_EN     = run & bus.EN & bus.Wr;
  assign bus.SRC_SEL   = run & (l_q == '0);
  assign bus.LAY_IDX   = l_q;
  assign bus.BUSY      = run;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    l_d     = l_q;
    wr_a_d  = wr_a_q;
    wr_b_d  = wr_b_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (!run) begin
      if (bus.START & bus.EN) begin
        state_d = RUN;
        b_d     = '0;
        l_d     = '0;
        err_d   = 1'b0;
      end
    end else if (bus.EN) begin
      err_d = err_q | (bus.FIRST != (l_q == '0));
      if (!bus.Wr) begin
        wr_a_d = rd_a;
        wr_b_d = rd_b;
      end else begin
        b_d = last_b ? '0 : b_q + ButtWL'(1);
        if (last_b) begin
          l_d     = last_l ? '0 : l_q + LayWL'(1);
          state_d = last_l ? IDLE : RUN;
          done_d  = last_l;
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      b_q     <= '0;
      l_q     <= '0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      l_q     <= l_d;
      wr_a_q  <= wr_a_d;
      wr_b_q  <= wr_b_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// tb_fft_iter_addr_gen: randomized checks of fft_iter_addr_gen against a butterfly-index reference model
module tb_fft_iter_addr_gen;
  logic CLK = 1'b0;
  logic RST_N;
  fft_iter_addr_gen_if #(.LayWL(3), .ButtWL(4)) bus ();
  fft_iter_addr_gen #(.LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );
  always #5 CLK = ~CLK;
  int n_tests = 0;
  int n_fail  = 0;
  // model: m_k counts completed butterflies of the transform (0..79)
  bit m_run, m_done, m_err;
  int m_k, m_wa, m_wb;
  int s_rda, s_rdb, s_w, s_wra, s_wrb;
  bit s_done, s_err, s_wren;
  int hits[32];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit en, input bit st, input bit wr, input bit fi, input bit rn);
    int l, b, p2, a, bb, w;
    bus.EN = en; bus.START = st; bus.Wr = wr; bus.FIRST = fi; RST_N = rn;
    l  = m_run ? m_k / 16 : 0;
    b  = m_run ? m_k % 16 : 0;
    p2 = 2 ** l;
    a  = (b / p2) * 2 * p2 + (b % p2);
    bb = a + p2;
    w  = (b % p2) * (2 ** (4 - l));
    #3;
    s_rda = int'(bus.RD_ADDR_A); s_rdb = int'(bus.RD_ADDR_B); s_w = int'(bus.W_ADDR);
    s_wra = int'(bus.WR_ADDR_A); s_wrb = int'(bus.WR_ADDR_B);
    s_done = bus.DONE; s_err = bus.ERR; s_wren = bus.WR_EN;
    chk("rd_a", bus.RD_ADDR_A, m_run ? a : 0);
    chk("rd_b", bus.RD_ADDR_B, m_run ? bb : 0);
    chk("w_addr", bus.W_ADDR, m_run ? w : 0);
    chk("wr_a", bus.WR_ADDR_A, m_wa);
    chk("wr_b", bus.WR_ADDR_B, m_wb);
    chk("rd_en", bus.RD_EN, m_run && en && !wr);
    chk("wr_en", bus.WR_EN, m_run && en && wr);
    chk("src_sel", bus.SRC_SEL, m_run && l == 0);
    chk("lay_idx", bus.LAY_IDX, l);
    chk("busy", bus.BUSY, m_run);
    chk("done", bus.DONE, m_done);
    chk("err", bus.ERR, m_err);
    @(posedge CLK);
    if (!rn) begin
      m_run = 0; m_done = 0; m_err = 0; m_k = 0; m_wa = 0; m_wb = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (st && en) begin m_run = 1; m_k = 0; m_err = 0; end
      end else if (en) begin
        if (fi != (l == 0)) m_err = 1;
        if (!wr) begin m_wa = a; m_wb = bb; end
        else begin
          m_k++;
          if (m_k == 80) begin m_run = 0; m_done = 1; m_k = 0; end
        end
      end
    end
    #1;
  endtask
  task automatic run_xform(input int gap_pct, input int bad_k, output int cyc, output int gaps);
    bit ph, en, fi, pre_run;
    int pre_k, ones;
    foreach (hits[i]) hits[i] = 0;
    cycle(1, 1, 0, 0, 1);
    ph = 0; cyc = -1; gaps = 0;
    for (int n = 1; n < 2000; n++) begin
      en = $urandom_range(99) >= gap_pct;
      fi = (m_k / 16 == 0) ^ (m_k == bad_k);
      pre_k = m_k; pre_run = m_run;
      cycle(en, 0, ph, fi, 1);
      if (n == 1) begin
        chk("first_rd_a", s_rda, 0);
        chk("first_rd_b", s_rdb, 1);
        chk("start_err_clr", s_err, 0);
      end
      if (s_done) begin cyc = n; break; end
      if (!en) gaps++;
      if (gap_pct == 0 && !ph) begin
        if (pre_k == 5)  begin chk("l0b5_a", s_rda, 10); chk("l0b5_b", s_rdb, 11); chk("l0b5_w", s_w, 0); end
        if (pre_k == 37) begin chk("l2b5_a", s_rda, 9);  chk("l2b5_b", s_rdb, 13); chk("l2b5_w", s_w, 4); end
        if (pre_k == 79) begin chk("l4b15_a", s_rda, 15); chk("l4b15_b", s_rdb, 31); chk("l4b15_w", s_w, 15); end
      end
      if (pre_run && en && ph && s_wren) begin
        hits[s_wra]++; hits[s_wrb]++;
        if (pre_k % 16 == 15) begin
          ones = 0;
          foreach (hits[i]) if (hits[i] == 1) ones++;
          chk("layer_cov", ones, 32);
          foreach (hits[i]) hits[i] = 0;
        end
      end
      if (en && pre_run) ph = !ph;
    end
    if (cyc < 0) chk("done_timeout", 0, 1);
  endtask
  initial begin
    int cyc, gaps;
    bit ph;
    m_run = 0; m_done = 0; m_err = 0; m_k = 0; m_wa = 0; m_wb = 0;
    bus.EN = 0; bus.START = 0; bus.Wr = 0; bus.FIRST = 0; RST_N = 0;
    @(posedge CLK); #1;
    for (int i = 0; i < 8; i++)
      cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)), 0);
    run_xform(0, -1, cyc, gaps);
    chk("done_cycle", cyc, 161);
    cycle(1, 0, 0, 0, 1);
    for (int r = 0; r < 2; r++) begin
      run_xform(30, -1, cyc, gaps);
      chk("done_delay", cyc, 161 + gaps);
      cycle(0, 0, 0, 0, 1);
    end
    run_xform(0, 3, cyc, gaps);
    chk("err_l0_at_done", s_err, 1);
    cycle(1, 0, 0, 1, 1);
    run_xform(0, 50, cyc, gaps);
    chk("err_l3_at_done", s_err, 1);
    cycle(1, 1, 0, 0, 1);
    ph = 0;
    for (int i = 0; i < 400 && !(m_k == 39 && !ph); i++) begin
      cycle(1, 0, ph, m_k < 16, 1);
      ph = !ph;
    end
    chk("abort_reach", m_k, 39);
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 1);
      chk("abort_no_done", s_done, 0);
    end
    run_xform(10, -1, cyc, gaps);
    chk("restart_done", cyc, 161 + gaps);
    cycle(1, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
